// File: rtl/count_arbiter.sv
// Round-robin arbiter/sequencer for the shared loadable up-counter.
// Grants one of two requesters, loads and steps the counter, and returns the result via req/done.
module count_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] start0,
    input  logic [WIDTH-1:0] start1,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_ld,
    output logic             cnt_en,
    output logic [WIDTH-1:0] cnt_data,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic             sel, sel_nx;
    logic             ptr, ptr_nx;
    logic [WIDTH-1:0] start_q, start_nx;
    logic [WIDTH-1:0] rem, rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 1'b0;
            ptr     <= 1'b0;
            start_q <= '0;
            rem     <= '0;
        end else begin
            state   <= state_nx;
            sel     <= sel_nx;
            ptr     <= ptr_nx;
            start_q <= start_nx;
            rem     <= rem_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        start_nx = start_q;
        rem_nx   = rem;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    // On contention the pointer decides; otherwise the lone requester wins.
                    sel_nx   = (req == 2'b11) ? ptr : req[1];
                    start_nx = sel_nx ? start1 : start0;
                    rem_nx   = sel_nx ? len1 : len0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = (rem == '0) ? DONE : COUNT;
            end
            COUNT: begin
                rem_nx = rem - WIDTH'(1);
                if (rem == WIDTH'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!req[sel]) begin
                    state_nx = IDLE;
                    ptr_nx   = ~sel;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        gnt      = busy ? (sel ? 2'b10 : 2'b01) : 2'b00;
        cnt_data = busy ? start_q : '0;
        cnt_ld   = (state == LOAD);
        cnt_en   = (state == COUNT);
        done     = (state == DONE) ? gnt : 2'b00;
        result   = (state == DONE) ? cnt_q : '0;
    end

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter with a behavioural counter and job-level reference model.
module tb_count_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] start0, start1, len0, len1;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_ld, cnt_en, busy;
    logic [WIDTH-1:0] cnt_data, result;
    logic [1:0]       gnt, done;

    int               vectors     = 0;
    int               miscompares = 0;
    int               ld_total    = 0;
    int               en_total    = 0;
    int               gnt_both    = 0;
    logic [WIDTH-1:0] last_ld_data = '0;
    bit               model_ptr   = 1'b0;

    always #5 clk = ~clk;

    count_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req),
        .start0(start0), .start1(start1), .len0(len0), .len1(len1),
        .cnt_q(cnt_q), .cnt_ld(cnt_ld), .cnt_en(cnt_en), .cnt_data(cnt_data),
        .gnt(gnt), .done(done), .result(result), .busy(busy)
    );

    // Shared counter the arbiter drives; reset by the same rst.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (cnt_ld) cnt_q <= cnt_data;
        else if (cnt_en) cnt_q <= cnt_q + 8'd1;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (cnt_ld) begin
                ld_total++;
                last_ld_data = cnt_data;
            end
            if (cnt_en) en_total++;
            if (gnt == 2'b11) gnt_both++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [WIDTH-1:0] expect_result(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] l);
        return WIDTH'((int'(s) + int'(l)) % 256);
    endfunction

    // Waits (bounded) for done[g]; cyc counts negedges since the calling negedge.
    task automatic wait_done(input int g, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (done[g]) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Issues one job from IDLE and collects observations up to done; req stays high.
    task automatic run_job(input int g, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] l,
                           output int cyc, output bit to, output logic [1:0] gnt_first,
                           output int ld_d, output int en_d, output logic [WIDTH-1:0] data_seen);
        int ld0, en0;
        @(negedge clk);
        ld0 = ld_total;
        en0 = en_total;
        if (g == 0) begin start0 = s; len0 = l; end
        else begin start1 = s; len1 = l; end
        req[g] = 1'b1;
        @(negedge clk);
        gnt_first = gnt;
        cyc = 1;
        to  = 1'b0;
        if (!done[g]) begin
            wait_done(g, cyc, to);
            cyc++;
        end
        ld_d      = ld_total - ld0;
        en_d      = en_total - en0;
        data_seen = last_ld_data;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 2'b00;
        start0 = '0; start1 = '0; len0 = '0; len1 = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({gnt, done, cnt_ld, cnt_en, busy, cnt_data, result} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b done=%b ld=%b en=%b busy=%b data=%0d res=%0d expected all 0",
                     gnt, done, cnt_ld, cnt_en, busy, cnt_data, result);
        end
        rst = 1'b0;
        model_ptr = 1'b0;
    endtask

    task automatic test_single;
        int cyc, ld_d, en_d; bit to; logic [1:0] g1; logic [WIDTH-1:0] d;
        run_job(0, 8'd10, 8'd5, cyc, to, g1, ld_d, en_d, d);
        vectors++; if (to) begin miscompares++; $display("FAIL single_timeout: done never rose"); end
        vectors++; if (g1 !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b expected 01", g1); end
        vectors++; if (ld_d !== 1 || d !== 8'd10) begin miscompares++; $display("FAIL single_load: got %0d pulses data %0d expected 1 pulse data 10", ld_d, d); end
        vectors++; if (en_d !== 5) begin miscompares++; $display("FAIL single_en: got %0d expected 5", en_d); end
        vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL single_latency: got %0d expected 7", cyc); end
        vectors++; if (done !== 2'b01 || result !== 8'd15) begin miscompares++; $display("FAIL single_done: got done=%b res=%0d expected 01/15", done, result); end
        req[0] = 1'b0;
        @(negedge clk);
        vectors++; if ({busy, gnt, done, result} !== '0) begin miscompares++; $display("FAIL single_release: got busy=%b gnt=%b done=%b res=%0d expected 0", busy, gnt, done, result); end
        model_ptr = 1'b1;
    endtask

    task automatic test_zero_len;
        int cyc, ld_d, en_d; bit to; logic [1:0] g1; logic [WIDTH-1:0] d;
        run_job(1, 8'd77, 8'd0, cyc, to, g1, ld_d, en_d, d);
        vectors++; if (to || g1 !== 2'b10) begin miscompares++; $display("FAIL zero_gnt: got %b timeout=%0d expected 10", g1, to); end
        vectors++; if (ld_d !== 1 || en_d !== 0) begin miscompares++; $display("FAIL zero_pulses: got ld=%0d en=%0d expected 1/0", ld_d, en_d); end
        vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL zero_latency: got %0d expected 2", cyc); end
        vectors++; if (done !== 2'b10 || result !== 8'd77) begin miscompares++; $display("FAIL zero_done: got done=%b res=%0d expected 10/77", done, result); end
        req[1] = 1'b0;
        @(negedge clk);
        model_ptr = 1'b0;
    endtask

    task automatic test_wrap;
        int cyc, ld_d, en_d; bit to; logic [1:0] g1; logic [WIDTH-1:0] d;
        run_job(0, 8'd250, 8'd10, cyc, to, g1, ld_d, en_d, d);
        vectors++; if (to || en_d !== 10) begin miscompares++; $display("FAIL wrap_en: got %0d timeout=%0d expected 10", en_d, to); end
        vectors++; if (result !== 8'd4) begin miscompares++; $display("FAIL wrap_result: got %0d expected 4", result); end
        req[0] = 1'b0;
        @(negedge clk);
        model_ptr = 1'b1;
    endtask

    task automatic test_contention;
        int cyc, en0; bit to;
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        start0 = 8'd20; len0 = 8'd3; start1 = 8'd100; len1 = 8'd2;
        req = 2'b11;
        rst = 1'b0;
        wait_done(0, cyc, to);
        vectors++; if (to || done !== 2'b01 || result !== 8'd23) begin miscompares++; $display("FAIL cont_first: got done=%b res=%0d expected 01/23", done, result); end
        en0 = en_total;
        req[0] = 1'b0;
        wait_done(1, cyc, to);
        vectors++; if (to || done !== 2'b10 || result !== 8'd102) begin miscompares++; $display("FAIL cont_second: got done=%b res=%0d expected 10/102", done, result); end
        vectors++; if (en_total - en0 !== 2) begin miscompares++; $display("FAIL cont_second_en: got %0d expected 2", en_total - en0); end
        req[1] = 1'b0;
        @(negedge clk);
        req = 2'b11;
        wait_done(0, cyc, to);
        vectors++; if (to || done !== 2'b01 || gnt !== 2'b01) begin miscompares++; $display("FAIL cont_again: got done=%b gnt=%b expected 01/01", done, gnt); end
        req = 2'b00;
        @(negedge clk);
        model_ptr = 1'b1;
    endtask

    task automatic test_held;
        int cyc, ld_d, en_d, ld0; bit to; logic [1:0] g1; logic [WIDTH-1:0] d;
        run_job(0, 8'd5, 8'd2, cyc, to, g1, ld_d, en_d, d);
        start1 = 8'd9; len1 = 8'd1; req[1] = 1'b1;
        ld0 = ld_total;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (done !== 2'b01 || result !== 8'd7) begin miscompares++; $display("FAIL held_done: cycle %0d got done=%b res=%0d expected 01/7", k, done, result); end
        end
        req[0] = 1'b0;
        @(negedge clk);
        vectors++; if (gnt !== 2'b00 || busy !== 1'b0 || ld_total !== ld0) begin miscompares++; $display("FAIL held_idle: got gnt=%b busy=%b new_ld=%0d expected 00/0/0", gnt, busy, ld_total - ld0); end
        @(negedge clk);
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL held_next_gnt: got %b expected 10", gnt); end
        wait_done(1, cyc, to);
        vectors++; if (to || result !== 8'd10) begin miscompares++; $display("FAIL held_second: got res=%0d timeout=%0d expected 10", result, to); end
        req[1] = 1'b0;
        @(negedge clk);
        model_ptr = 1'b0;
    endtask

    task automatic test_reset_mid;
        int en_seen, cyc, ld0, en0; bit to;
        @(negedge clk);
        start0 = 8'd3; len0 = 8'd8; req[0] = 1'b1;
        en_seen = 0;
        for (int k = 0; k < 50 && en_seen < 3; k++) begin
            @(negedge clk);
            if (cnt_en) en_seen++;
        end
        vectors++; if (en_seen !== 3) begin miscompares++; $display("FAIL rmid_reach: got %0d enables expected 3", en_seen); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({gnt, done, cnt_en, cnt_ld, busy} !== '0) begin miscompares++; $display("FAIL rmid_async: got gnt=%b done=%b en=%b ld=%b busy=%b expected 0", gnt, done, cnt_en, cnt_ld, busy); end
        @(negedge clk);
        rst = 1'b0;
        ld0 = ld_total; en0 = en_total;
        wait_done(0, cyc, to);
        vectors++; if (to || cyc !== 10) begin miscompares++; $display("FAIL rmid_latency: got %0d timeout=%0d expected 10", cyc, to); end
        vectors++; if (ld_total - ld0 !== 1 || en_total - en0 !== 8) begin miscompares++; $display("FAIL rmid_pulses: got ld=%0d en=%0d expected 1/8", ld_total - ld0, en_total - en0); end
        vectors++; if (result !== 8'd11) begin miscompares++; $display("FAIL rmid_result: got %0d expected 11", result); end
        req[0] = 1'b0;
        @(negedge clk);
        model_ptr = 1'b1;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] s [2];
        logic [WIDTH-1:0] l [2];
        logic [1:0] pat;
        int first, second, cyc, ld0, en0; bit to;
        for (int r = 0; r < 40; r++) begin
            pat = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                s[i] = WIDTH'($urandom_range(0, 255));
                l[i] = (($urandom % 8) == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom_range(0, 12));
            end
            first = (pat == 2'b11) ? int'(model_ptr) : ((pat == 2'b10) ? 1 : 0);
            start0 = s[0]; len0 = l[0]; start1 = s[1]; len1 = l[1];
            ld0 = ld_total; en0 = en_total;
            req = pat;
            wait_done(first, cyc, to);
            vectors++;
            if (to || done !== 2'(1 << first) || result !== expect_result(s[first], l[first]) || cyc !== int'(l[first]) + 2) begin
                miscompares++;
                $display("FAIL rand_first: round %0d got done=%b res=%0d lat=%0d expected %b/%0d/%0d",
                         r, done, result, cyc, 2'(1 << first), expect_result(s[first], l[first]), int'(l[first]) + 2);
            end
            vectors++;
            if (ld_total - ld0 !== 1 || en_total - en0 !== int'(l[first]) || last_ld_data !== s[first]) begin
                miscompares++;
                $display("FAIL rand_first_pulses: round %0d got ld=%0d en=%0d data=%0d expected 1/%0d/%0d",
                         r, ld_total - ld0, en_total - en0, last_ld_data, l[first], s[first]);
            end
            model_ptr = (first == 0);
            if (pat == 2'b11) begin
                second = 1 - first;
                ld0 = ld_total; en0 = en_total;
                req[first] = 1'b0;
                wait_done(second, cyc, to);
                vectors++;
                if (to || done !== 2'(1 << second) || result !== expect_result(s[second], l[second]) || cyc !== int'(l[second]) + 3) begin
                    miscompares++;
                    $display("FAIL rand_second: round %0d got done=%b res=%0d lat=%0d expected %b/%0d/%0d",
                             r, done, result, cyc, 2'(1 << second), expect_result(s[second], l[second]), int'(l[second]) + 3);
                end
                vectors++;
                if (ld_total - ld0 !== 1 || en_total - en0 !== int'(l[second])) begin
                    miscompares++;
                    $display("FAIL rand_second_pulses: round %0d got ld=%0d en=%0d expected 1/%0d", r, ld_total - ld0, en_total - en0, l[second]);
                end
                model_ptr = (second == 0);
            end
            req = 2'b00;
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || result !== '0 || cnt_data !== '0) begin
                miscompares++;
                $display("FAIL rand_idle: round %0d got busy=%b res=%0d data=%0d expected 0", r, busy, result, cnt_data);
            end
        end
    endtask

    task automatic test_onehot_gnt;
        vectors++;
        if (gnt_both !== 0) begin
            miscompares++;
            $display("FAIL gnt_onehot: got %0d cycles with gnt=11 expected 0", gnt_both);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_wrap();
        test_contention();
        test_held();
        test_reset_mid();
        test_random();
        test_onehot_gnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
